ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter, the send direction that complements the existing `ps2_keyboard` receiver. It lets the design send command bytes to the keyboard on the shared PS/2 port: 0xED set-LEDs, 0xFF reset, 0xF3 typematic. The block drives the bidirectional `PS2_CLK`/`PS2_DAT` lines only through open-drain enables. The top level ties each line to `1'bz` or `1'b0`, so the existing receiver keeps listening on the same pins.

---
 rtl/ps2_host_tx.sv | 136 +++++++++++++
 tb/tb_ps2_host_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int REQ_CYCLES     = 100,
   parameter int START_TIMEOUT  = 750000,
   parameter int PACKET_TIMEOUT = 100000
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   input  logic [7:0] command,
   input  logic       send_command,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       command_sent,
   output logic       ack_error,
   output logic       timeout_error
);

   localparam int MAX_AB  = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int MAX_CD  = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
   localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(REQ_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] PACKET_LAST  = CNT_W'(PACKET_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_WAIT_CLK, S_DATA, S_ACK, S_WAIT_IDLE, S_ABORT
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [9:0]       frame;
   logic [3:0]       bit_idx;
   logic             tx_low;
   logic             clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
   logic             fall, pkt_phase, pkt_next, pkt_expire;

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk_in;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_dat_in;
         dat_s2   <= dat_s1;
      end
   end

   assign fall       = clk_prev & ~clk_s2;
   assign pkt_phase  = (state == S_DATA) || (state == S_ACK) || (state == S_WAIT_IDLE);
   assign pkt_next   = (state_next == S_DATA) || (state_next == S_ACK) || (state_next == S_WAIT_IDLE);
   assign pkt_expire = pkt_phase && (cnt == PACKET_LAST);

   always_ff @(posedge CLOCK_50) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_next;
   end

   // Timeouts are tested before edges so a coincident fall loses.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:      if (send_command) state_next = S_INHIBIT;
         S_INHIBIT:   if (cnt == INHIBIT_LAST) state_next = S_REQ;
         S_REQ:       if (cnt == REQ_LAST) state_next = S_WAIT_CLK;
         S_WAIT_CLK:  if (cnt == START_LAST) state_next = S_ABORT;
                      else if (fall) state_next = S_DATA;
         S_DATA:      if (pkt_expire) state_next = S_ABORT;
                      else if (fall && bit_idx == 4'd9) state_next = S_ACK;
         S_ACK:       if (pkt_expire) state_next = S_ABORT;
                      else if (fall) state_next = S_WAIT_IDLE;
         S_WAIT_IDLE: if (pkt_expire) state_next = S_ABORT;
                      else if (clk_s2 && dat_s2) state_next = S_IDLE;
         S_ABORT:     state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   // The packet phases share one running count from the first device edge.
   always_ff @(posedge CLOCK_50) begin
      if (RESET || state == S_IDLE)
         cnt <= '0;
      else if (state_next != state && !(pkt_phase && pkt_next))
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         frame         <= '0;
         bit_idx       <= '0;
         tx_low        <= 1'b0;
         ack_error     <= 1'b0;
         timeout_error <= 1'b0;
      end else begin
         if (state == S_IDLE && send_command) begin
            frame         <= {1'b1, ~^command, command};
            ack_error     <= 1'b0;
            timeout_error <= 1'b0;
         end
         if (state == S_WAIT_CLK && state_next == S_DATA) begin
            tx_low  <= ~frame[0];
            bit_idx <= 4'd1;
         end
         if (state == S_DATA && fall && state_next != S_ABORT) begin
            tx_low  <= ~frame[bit_idx];
            bit_idx <= bit_idx + 4'd1;
         end
         if (state == S_ACK && state_next == S_WAIT_IDLE)
            ack_error <= dat_s2;
         if (state_next == S_ABORT)
            timeout_error <= 1'b1;
      end
   end

   always_comb begin
      ps2_clk_oe   = (state == S_INHIBIT) || (state == S_REQ);
      ps2_dat_oe   = (state == S_REQ) || (state == S_WAIT_CLK) ||
                     (((state == S_DATA) || (state == S_ACK)) && tx_low);
      busy         = (state != S_IDLE);
      command_sent = (state == S_ABORT) || (state == S_WAIT_IDLE && state_next == S_IDLE);
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

   localparam int INH   = 20;
   localparam int REQ   = 5;
   localparam int ST_TO = 200;
   localparam int PK_TO = 400;
   localparam int HALF  = 8;

   logic       CLOCK_50 = 1'b0;
   logic       RESET = 1'b1;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic [7:0] command = 8'h00;
   logic       send_command = 1'b0;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe, busy, command_sent, ack_error, timeout_error;

   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .REQ_CYCLES(REQ),
      .START_TIMEOUT(ST_TO),
      .PACKET_TIMEOUT(PK_TO)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RESET(RESET),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .command(command),
      .send_command(send_command),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .busy(busy),
      .command_sent(command_sent),
      .ack_error(ack_error),
      .timeout_error(timeout_error)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   int sent_cnt = 0;
   int last_sent_cyc = 0;
   int tests = 0;
   int fails = 0;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   always @(negedge CLOCK_50) begin
      if (command_sent === 1'b1) begin
         sent_cnt = sent_cnt + 1;
         last_sent_cyc = cyc;
      end
   end

   typedef struct {
      logic [7:0]  cmd;
      logic        ack_val;
      logic [10:0] exp_bits;
      logic        exp_ack_err;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_send(input logic [7:0] c);
      @(negedge CLOCK_50);
      command = c;
      send_command = 1'b1;
      @(negedge CLOCK_50);
      send_command = 1'b0;
      check("busy_rise", 32'(busy), 32'd1);
      check("clk_oe_rise", 32'(ps2_clk_oe), 32'd1);
   endtask

   task automatic measure_req();
      int n_inh = 0;
      int n_req = 0;
      while (ps2_clk_oe && !ps2_dat_oe && n_inh < 1000) begin
         n_inh++;
         @(negedge CLOCK_50);
      end
      while (ps2_clk_oe && ps2_dat_oe && n_req < 1000) begin
         n_req++;
         @(negedge CLOCK_50);
      end
      check("inhibit_len", 32'(n_inh), 32'(INH));
      check("req_len", 32'(n_req), 32'(REQ));
   endtask

   task automatic device_run(input int stop_after, input logic ack_val,
                             output logic [10:0] seen, output int first_fall);
      int n = 0;
      seen = '1;
      first_fall = cyc;
      while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < 1000) begin
         @(negedge CLOCK_50);
         n++;
      end
      if (n >= 1000) begin
         tests++;
         fails++;
         $display("FAIL dev_release_wait: got no release, required release within 1000 cycles");
         return;
      end
      seen[0] = ps2_dat_in;
      repeat (4) @(negedge CLOCK_50);
      for (int i = 1; i <= 10; i++) begin
         dev_clk = 1'b0;
         if (i == 1) first_fall = cyc;
         repeat (HALF) @(negedge CLOCK_50);
         seen[i] = ps2_dat_in;
         dev_clk = 1'b1;
         repeat (HALF) @(negedge CLOCK_50);
         if (i == stop_after) return;
      end
      dev_dat = ack_val;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      dev_dat = 1'b1;
   endtask

   task automatic wait_sent(input int s0);
      int n = 0;
      while (sent_cnt == s0 && n < 2000) begin
         @(negedge CLOCK_50);
         n++;
      end
      check("sent_seen", 32'(sent_cnt != s0), 32'd1);
      @(negedge CLOCK_50);
   endtask

   initial begin
      logic [10:0] seen;
      int          ff;
      int          s0;
      int          t0;

      vecs[0] = '{8'hED, 1'b0, 11'h7DA, 1'b0};
      vecs[1] = '{8'h01, 1'b0, 11'h402, 1'b0};
      vecs[2] = '{8'h00, 1'b0, 11'h600, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 11'h7FE, 1'b1};
      vecs[4] = '{8'hF3, 1'b0, 11'h7E6, 1'b0};

      RESET = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sent", 32'(command_sent), 32'd0);
      check("rst_ack_err", 32'(ack_error), 32'd0);
      check("rst_to_err", 32'(timeout_error), 32'd0);
      RESET = 1'b0;

      for (int i = 0; i < 5; i++) begin
         s0 = sent_cnt;
         start_send(vecs[i].cmd);
         measure_req();
         device_run(0, vecs[i].ack_val, seen, ff);
         wait_sent(s0);
         check("frame_bits", 32'(seen), 32'(vecs[i].exp_bits));
         check("ack_error", 32'(ack_error), 32'(vecs[i].exp_ack_err));
         check("timeout_error", 32'(timeout_error), 32'd0);
         check("sent_once", 32'(sent_cnt - s0), 32'd1);
         check("busy_fall", 32'(busy), 32'd0);
         check("lines_free", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      end

      s0 = sent_cnt;
      start_send(8'hFF);
      measure_req();
      t0 = cyc;
      wait_sent(s0);
      check("start_to_len", 32'(last_sent_cyc - t0), 32'(ST_TO));
      check("start_to_err", 32'(timeout_error), 32'd1);
      check("start_to_sent", 32'(sent_cnt - s0), 32'd1);
      check("start_to_free", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);

      s0 = sent_cnt;
      start_send(8'h3C);
      measure_req();
      device_run(4, 1'b0, seen, ff);
      check("pkt_to_bits", 32'(seen[4:0]), 32'h18);
      wait_sent(s0);
      check("pkt_to_len", 32'(last_sent_cyc - ff), 32'(PK_TO + 3));
      check("pkt_to_err", 32'(timeout_error), 32'd1);
      check("pkt_to_ack", 32'(ack_error), 32'd0);
      check("pkt_to_free", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);

      s0 = sent_cnt;
      start_send(8'hA5);
      repeat (3) @(negedge CLOCK_50);
      command = 8'h00;
      send_command = 1'b1;
      @(negedge CLOCK_50);
      send_command = 1'b0;
      device_run(0, 1'b0, seen, ff);
      wait_sent(s0);
      check("drop_bits", 32'(seen), 32'h74A);
      check("drop_sent", 32'(sent_cnt - s0), 32'd1);
      check("drop_to_err", 32'(timeout_error), 32'd0);

      start_send(8'h55);
      measure_req();
      device_run(3, 1'b0, seen, ff);
      check("mid_busy", 32'(busy), 32'd1);
      s0 = sent_cnt;
      RESET = 1'b1;
      @(negedge CLOCK_50);
      check("mid_rst_outs", 32'({ps2_clk_oe, ps2_dat_oe, busy, command_sent, ack_error, timeout_error}), 32'd0);
      RESET = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      check("mid_rst_nosent", 32'(sent_cnt - s0), 32'd0);
      check("mid_rst_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
